vec_pipe_backend: RTL and testbench

//  Parametrised vector EX/MEM/WB back-end for the SIMD FIR core: LANES x W-bit lanes, configurable register-address width.

---
 rtl/vec_pipe_pkg.sv | 34 +++
 rtl/vec_lane_alu.sv | 61 ++++++
 rtl/vec_pipe_backend.sv | 122 ++++++++++++
 tb/tb_vec_pipe_backend.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pipe_pkg.sv
// Shared types and helpers for the vector EX/MEM/WB back-end.
package vec_pipe_pkg;

    // Stage control carries the widest supported register address; narrower builds zero-extend.
    localparam int unsigned RaWMax = 16;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluMulq  = 4'd2,
        AluAnd   = 4'd3,
        AluOr    = 4'd4,
        AluXor   = 4'd5,
        AluPassb = 4'd6,
        AluSra   = 4'd7
    } aluop_e;

    typedef struct packed {
        logic              valid;
        logic [RaWMax-1:0] wa3;
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
    } stage_ctrl_t;

    function automatic logic signed [127:0] lane_sat_max(int unsigned w);
        return (128'sd1 <<< (w - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] lane_sat_min(int unsigned w);
        return -(128'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational SIMD lane. VEC_SAT_EN selects saturating ADD/SUB/MULQ with
// round-half-up MULQ; otherwise those ops wrap and MULQ truncates.
module vec_lane_alu
    import vec_pipe_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 15
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  aluop_e       op,
    output logic [W-1:0] y
);

    localparam int unsigned ShW = $clog2(W);

    logic signed [2*W-1:0] a_x, b_x, sum, diff, prod, mulq;

    assign a_x  = {{W{a[W-1]}}, a};
    assign b_x  = {{W{b[W-1]}}, b};
    assign sum  = a_x + b_x;
    assign diff = a_x - b_x;
    assign prod = a_x * b_x;

`ifdef VEC_SAT_EN
    localparam int unsigned RndSh = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic signed [2*W-1:0] Rnd    = (FRAC > 0) ? ((2*W)'(1) << RndSh) : '0;
    localparam logic signed [2*W-1:0] SatMax = (2*W)'(lane_sat_max(W));
    localparam logic signed [2*W-1:0] SatMin = (2*W)'(lane_sat_min(W));

    assign mulq = (prod + Rnd) >>> FRAC;

    function automatic logic [W-1:0] fit(logic signed [2*W-1:0] v);
        if (v > SatMax) return SatMax[W-1:0];
        if (v < SatMin) return SatMin[W-1:0];
        return v[W-1:0];
    endfunction
`else
    assign mulq = prod >>> FRAC;

    function automatic logic [W-1:0] fit(logic signed [2*W-1:0] v);
        return W'(v);
    endfunction
`endif

    always_comb begin
        y = '0;
        case (op)
            AluAdd:   y = fit(sum);
            AluSub:   y = fit(diff);
            AluMulq:  y = fit(mulq);
            AluAnd:   y = a & b;
            AluOr:    y = a | b;
            AluXor:   y = a ^ b;
            AluPassb: y = b;
            AluSra:   y = W'($signed(a) >>> b[ShW-1:0]);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/vec_pipe_backend.sv
// Vector EX/MEM/WB back-end: pipeline registers, forwarding, W->D bypass and load-use stall.
// Lane arithmetic saturates when built with VEC_SAT_EN.
module vec_pipe_backend
    import vec_pipe_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned W     = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned FRAC  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [RA_W-1:0]     d_ra1,
    input  logic [RA_W-1:0]     d_ra2,
    input  logic                d_use1,
    input  logic                d_use2,
    input  logic [RA_W-1:0]     d_wa3,
    input  logic                d_regwrite,
    input  logic                d_memtoreg,
    input  logic                d_memwrite,
    input  logic [3:0]          d_aluop,
    input  logic [LANES*W-1:0]  d_rd1,
    input  logic [LANES*W-1:0]  d_rd2,
    input  logic                flush_e,
    output logic                stall_d,
    output logic                m_memwrite,
    output logic [LANES*W-1:0]  m_store_data,
    input  logic [LANES*W-1:0]  m_rdata,
    output logic                w_we,
    output logic [RA_W-1:0]     w_wa,
    output logic [LANES*W-1:0]  w_wd
);

    localparam int unsigned VW = LANES * W;

    function automatic logic [RaWMax-1:0] ext_ra(logic [RA_W-1:0] ra);
        return RaWMax'(ra);
    endfunction

    stage_ctrl_t       e_q, e_d, m_q, w_q;
    aluop_e            e_op_q;
    logic [RaWMax-1:0] e_ra1_q, e_ra2_q;
    logic [VW-1:0]     e_a_q, e_b_q, e_a_d, e_b_d;
    logic [VW-1:0]     src_a, src_b, alu_y;
    logic [VW-1:0]     m_alu_q, m_sd_q, w_alu_q, w_ld_q;
    logic              m_fwd_ok;

    // A load in E cannot feed D's op until it reaches W; one bubble, then forward from W.
    assign stall_d = d_valid & e_q.valid & e_q.regwrite & e_q.memtoreg &
                     ((d_use1 & (e_q.wa3 == ext_ra(d_ra1))) |
                      (d_use2 & (e_q.wa3 == ext_ra(d_ra2))));

    assign w_we         = w_q.valid & w_q.regwrite;
    assign w_wa         = w_q.wa3[RA_W-1:0];
    assign w_wd         = w_q.memtoreg ? w_ld_q : w_alu_q;
    assign m_memwrite   = m_q.valid & m_q.memwrite;
    assign m_store_data = m_sd_q;
    assign m_fwd_ok     = m_q.valid & m_q.regwrite & ~m_q.memtoreg;

    always_comb begin
        e_d.valid    = d_valid & ~stall_d & ~flush_e;
        e_d.wa3      = ext_ra(d_wa3);
        e_d.regwrite = d_regwrite & ~d_memwrite;
        e_d.memtoreg = d_memtoreg;
        e_d.memwrite = d_memwrite;
        e_a_d = (w_we && (w_q.wa3 == ext_ra(d_ra1))) ? w_wd : d_rd1;
        e_b_d = (w_we && (w_q.wa3 == ext_ra(d_ra2))) ? w_wd : d_rd2;
    end

    always_comb begin
        src_a = e_a_q;
        src_b = e_b_q;
        if (m_fwd_ok && (m_q.wa3 == e_ra1_q))  src_a = m_alu_q;
        else if (w_we && (w_q.wa3 == e_ra1_q)) src_a = w_wd;
        if (m_fwd_ok && (m_q.wa3 == e_ra2_q))  src_b = m_alu_q;
        else if (w_we && (w_q.wa3 == e_ra2_q)) src_b = w_wd;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vec_lane_alu #(
            .W    (W),
            .FRAC (FRAC)
        ) u_alu (
            .a  (src_a[i*W +: W]),
            .b  (src_b[i*W +: W]),
            .op (e_op_q),
            .y  (alu_y[i*W +: W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            e_op_q  <= AluAdd;
            e_ra1_q <= '0;
            e_ra2_q <= '0;
            e_a_q   <= '0;
            e_b_q   <= '0;
            m_alu_q <= '0;
            m_sd_q  <= '0;
            w_alu_q <= '0;
            w_ld_q  <= '0;
        end else begin
            e_q     <= e_d;
            e_op_q  <= aluop_e'(d_aluop);
            e_ra1_q <= ext_ra(d_ra1);
            e_ra2_q <= ext_ra(d_ra2);
            e_a_q   <= e_a_d;
            e_b_q   <= e_b_d;
            m_q     <= e_q;
            m_alu_q <= alu_y;
            m_sd_q  <= src_b;
            w_q     <= m_q;
            w_alu_q <= m_alu_q;
            w_ld_q  <= m_rdata;
        end
    end

endmodule

// File: tb/tb_vec_pipe_backend.sv
// Scoreboard bench for vec_pipe_backend: directed ops push expected writes/stores,
// a negedge monitor pops and compares them, including arrival cycle.
module tb_vec_pipe_backend;

    localparam int unsigned LANES = 16;
    localparam int unsigned W     = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned FRAC  = 15;
    localparam int unsigned VW    = LANES * W;

    typedef logic [VW-1:0] vec_t;
    typedef struct { int cyc; logic [4:0] wa; vec_t wd; } wexp_t;
    typedef struct { int cyc; vec_t sd; } sexp_t;

    localparam int KAlu = 0, KLoad = 1, KStore = 2, KFlush = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            d_valid = 1'b0;
    logic [RA_W-1:0] d_ra1 = '0, d_ra2 = '0, d_wa3 = '0;
    logic            d_use1 = 1'b0, d_use2 = 1'b0;
    logic            d_regwrite = 1'b0, d_memtoreg = 1'b0, d_memwrite = 1'b0;
    logic [3:0]      d_aluop = '0;
    vec_t            d_rd1, d_rd2, m_store_data, m_rdata, w_wd;
    logic            flush_e = 1'b0;
    logic            stall_d, m_memwrite, w_we;
    logic [RA_W-1:0] w_wa;

    vec_t       rf [32];
    logic       pl_en = 1'b0;
    logic [4:0] pl_a = '0;
    vec_t       pl_v = '0;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    wexp_t wq[$];
    sexp_t sq[$];

    vec_pipe_backend #(
        .LANES (LANES),
        .W     (W),
        .RA_W  (RA_W),
        .FRAC  (FRAC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_ra1        (d_ra1),
        .d_ra2        (d_ra2),
        .d_use1       (d_use1),
        .d_use2       (d_use2),
        .d_wa3        (d_wa3),
        .d_regwrite   (d_regwrite),
        .d_memtoreg   (d_memtoreg),
        .d_memwrite   (d_memwrite),
        .d_aluop      (d_aluop),
        .d_rd1        (d_rd1),
        .d_rd2        (d_rd2),
        .flush_e      (flush_e),
        .stall_d      (stall_d),
        .m_memwrite   (m_memwrite),
        .m_store_data (m_store_data),
        .m_rdata      (m_rdata),
        .w_we         (w_we),
        .w_wa         (w_wa),
        .w_wd         (w_wd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side register file: preload port, else the DUT write port.
    always @(posedge clk) begin
        if (pl_en) rf[pl_a] <= pl_v;
        else if (w_we) rf[w_wa] <= w_wd;
    end

    assign d_rd1 = rf[d_ra1];
    assign d_rd2 = rf[d_ra2];

    function automatic vec_t splat(logic [W-1:0] v);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic vec_t ramp(int base);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i*W +: W] = W'(base + i);
        return r;
    endfunction

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin : monitor
        wexp_t we;
        sexp_t se;
        if (!reset) begin
            if (w_we) begin
                if (wq.size() == 0) fail_evt("unexpected w_we");
                else begin
                    we = wq.pop_front();
                    chk("w_wa", vec_t'(w_wa), vec_t'(we.wa));
                    chk("w_wd", w_wd, we.wd);
                    chk("w cycle", vec_t'(cyc), vec_t'(we.cyc));
                end
            end
            if (m_memwrite) begin
                if (sq.size() == 0) fail_evt("unexpected m_memwrite");
                else begin
                    se = sq.pop_front();
                    chk("m_store_data", m_store_data, se.sd);
                    chk("store cycle", vec_t'(cyc), vec_t'(se.cyc));
                end
            end
        end
    end

    task automatic preload(input int a, input vec_t v);
        pl_en = 1'b1;
        pl_a  = 5'(a);
        pl_v  = v;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input int wa, input int ra1, input int ra2,
                         input int kind);
        d_valid    = 1'b1;
        d_aluop    = op;
        d_wa3      = 5'(wa);
        d_ra1      = 5'(ra1);
        d_ra2      = 5'(ra2);
        d_use1     = (kind == KAlu || kind == KFlush);
        d_use2     = (kind != KLoad);
        d_regwrite = (kind != KStore);
        d_memtoreg = (kind == KLoad);
        d_memwrite = (kind == KStore);
        flush_e    = (kind == KFlush);
    endtask

    // Presents one op in D until accepted; expected write at +3, store at +2 cycles.
    task automatic issue(input logic [3:0] op, input int wa, input int ra1, input int ra2,
                         input int kind, input vec_t exp, output int stalls);
        wexp_t we;
        sexp_t se;
        drive(op, wa, ra1, ra2, kind);
        stalls = 0;
        while (1'b1) begin
            @(negedge clk);
            if (!stall_d || stalls > 4) break;
            stalls++;
            @(posedge clk);
            #1;
        end
        if (kind == KAlu || kind == KLoad) begin
            we.cyc = cyc + 3; we.wa = 5'(wa); we.wd = exp;
            wq.push_back(we);
        end else if (kind == KStore) begin
            se.cyc = cyc + 2; se.sd = exp;
            sq.push_back(se);
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        flush_e = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() != 0 || sq.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (wq.size() != 0 || sq.size() != 0) fail_evt("scoreboard not drained");
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " w_we"}, vec_t'(w_we), '0);
        chk({tag, " w_wa"}, vec_t'(w_wa), '0);
        chk({tag, " w_wd"}, w_wd, '0);
        chk({tag, " m_memwrite"}, vec_t'(m_memwrite), '0);
        chk({tag, " m_store_data"}, m_store_data, '0);
        chk({tag, " stall_d"}, vec_t'(stall_d), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int   s;
        vec_t sra_exp;
        logic signed [W-1:0] t;

        m_rdata = splat(32'h100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");

        preload(0, splat(32'd9));
        preload(1, splat(32'd3));
        preload(2, splat(32'd5));
        preload(3, splat(32'd7));
        preload(10, ramp(5));
        preload(11, splat(32'h8000_0000));
        preload(12, ramp(32));
        preload(13, splat(32'h4000));
        preload(14, splat(32'hFFFF_FFFD));
        preload(15, splat(32'h7FFF_FFFF));
        preload(16, splat(32'd1));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back dependency through M.
        issue(4'd0, 4, 1, 1, KAlu, splat(32'd6), s);
        chk("stall add v4", vec_t'(s), '0);
        issue(4'd1, 5, 4, 1, KAlu, splat(32'd3), s);
        chk("stall sub v5", vec_t'(s), '0);
        drain();

        issue(4'd0, 1, 2, 3, KAlu, splat(32'd12), s);
        drain();

        // M result wins over older W result for the same register.
        issue(4'd0, 4, 0, 0, KAlu, splat(32'd18), s);
        issue(4'd0, 4, 4, 0, KAlu, splat(32'd27), s);
        issue(4'd1, 9, 4, 0, KAlu, splat(32'd18), s);

        // W->D bypass (v25 read 3 ops later) and W forward (v29 read 2 ops later).
        issue(4'd0, 25, 0, 0, KAlu, splat(32'd18), s);
        issue(4'd3, 26, 2, 3, KAlu, splat(32'd5), s);
        issue(4'd4, 27, 2, 3, KAlu, splat(32'd7), s);
        issue(4'd5, 28, 25, 2, KAlu, splat(32'd23), s);
        issue(4'd0, 29, 0, 2, KAlu, splat(32'd14), s);
        issue(4'd6, 30, 0, 3, KAlu, splat(32'd7), s);
        issue(4'd1, 31, 29, 2, KAlu, splat(32'd9), s);

        // Per-lane data, SRA using only low shift bits, undefined opcode.
        for (int i = 0; i < LANES; i++) begin
            t = 32'sh8000_0000;
            sra_exp[i*W +: W] = t >>> i;
        end
        issue(4'd0, 20, 10, 3, KAlu, ramp(12), s);
        issue(4'd7, 21, 11, 12, KAlu, sra_exp, s);
        issue(4'd15, 18, 2, 3, KAlu, '0, s);

        issue(4'd2, 22, 13, 13, KAlu, splat(32'h2000), s);
`ifdef VEC_SAT_EN
        issue(4'd2, 23, 14, 13, KAlu, splat(32'hFFFF_FFFF), s);
        issue(4'd0, 24, 15, 16, KAlu, splat(32'h7FFF_FFFF), s);
        issue(4'd1, 8, 11, 16, KAlu, splat(32'h8000_0000), s);
`else
        issue(4'd2, 23, 14, 13, KAlu, splat(32'hFFFF_FFFE), s);
        issue(4'd0, 24, 15, 16, KAlu, splat(32'h8000_0000), s);
        issue(4'd1, 8, 11, 16, KAlu, splat(32'h7FFF_FFFF), s);
`endif

        // Stores: plain, and store data forwarded from the op just ahead.
        issue(4'd0, 0, 0, 3, KStore, splat(32'd7), s);
        issue(4'd0, 19, 2, 2, KAlu, splat(32'd10), s);
        issue(4'd0, 0, 0, 19, KStore, splat(32'd10), s);
        drain();

        // Load-use: exactly one stall, value via W forward.
        issue(4'd0, 6, 0, 0, KLoad, splat(32'h100), s);
        chk("stall load", vec_t'(s), '0);
        issue(4'd0, 7, 6, 6, KAlu, splat(32'h200), s);
        chk("load-use stalls", vec_t'(s), vec_t'(1));
        drain();

        // Flushed op never writes; the next op completes.
        issue(4'd0, 17, 2, 2, KFlush, '0, s);
        issue(4'd0, 17, 3, 3, KAlu, splat(32'd14), s);
        drain();

        // Reset with an ADD in M, a store in E and an ADD in D.
        issue(4'd0, 26, 0, 0, KAlu, splat(32'd18), s);
        issue(4'd0, 0, 0, 2, KStore, splat(32'd5), s);
        drive(4'd0, 27, 1, 1, KAlu);
        reset = 1'b1;
        wq.delete();
        sq.delete();
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mid-reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(4'd0, 27, 2, 3, KAlu, splat(32'd12), s);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
